// File: rtl/mac_dot_sched_pkg.sv
// Shared types and constants for the dot-product scheduler that time-shares one MAC.
package mac_sched_pkg;

    localparam int OP_W  = 12;
    localparam int RES_W = 24;

    typedef logic signed [OP_W-1:0]  operand_t;
    typedef logic signed [RES_W-1:0] result_t;

    localparam result_t FMAX = {1'b0, {(RES_W-1){1'b1}}};
    localparam result_t FMIN = {1'b1, {(RES_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // The MAC clamps at either rail, so hitting a rail exactly means saturation.
    function automatic logic is_sat(input result_t v);
        return (v == FMAX) || (v == FMIN);
    endfunction

endpackage

// File: rtl/mac_dot_sched_if.sv
// Bundle of requester, MAC and result-consumer signals around the scheduler.
interface mac_dot_sched_if import mac_sched_pkg::*; #(
    parameter int AW = OP_W,
    parameter int FW = RES_W
);
    logic [1:0]    req;
    logic [AW-1:0] a0;
    logic [AW-1:0] b0;
    logic [AW-1:0] a1;
    logic [AW-1:0] b1;
    logic [1:0]    in_valid;
    logic [1:0]    in_ready;
    logic [AW-1:0] mac_a;
    logic [AW-1:0] mac_b;
    logic          mac_valid_in;
    logic          mac_clr;
    logic [FW-1:0] mac_f;
    logic          mac_valid_out;
    logic [FW-1:0] res;
    logic          res_id;
    logic          res_sat;
    logic          res_valid;
    logic          res_ready;

    modport slave (
        input  req, a0, b0, a1, b1, in_valid, mac_f, mac_valid_out, res_ready,
        output in_ready, mac_a, mac_b, mac_valid_in, mac_clr,
               res, res_id, res_sat, res_valid
    );

    modport master (
        output req, a0, b0, a1, b1, in_valid, mac_f, mac_valid_out, res_ready,
        input  in_ready, mac_a, mac_b, mac_valid_in, mac_clr,
               res, res_id, res_sat, res_valid
    );
endinterface

// File: rtl/mac_dot_sched_rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last time has priority.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt       = req[~last_grant] ? ~last_grant : last_grant;
    end

endmodule

// File: rtl/mac_dot_sched.sv
// Schedules VEC_LEN-beat dot-product jobs from two requesters onto a single shared MAC
// and holds each finished result until the consumer takes it.
module mac_dot_sched import mac_sched_pkg::*; #(
    parameter int VEC_LEN = 4,
    parameter int AW      = OP_W,
    parameter int FW      = RES_W
) (
    input logic            clk,
    input logic            reset,
    mac_dot_sched_if.slave bus
);

    localparam logic [7:0] LAST_BEAT = 8'(VEC_LEN - 1);
    localparam logic [7:0] ALL_DONE  = 8'(VEC_LEN);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_grant_q, last_grant_d;
    logic [7:0]    issue_cnt_q, issue_cnt_d;
    logic [7:0]    done_cnt_q, done_cnt_d;
    logic [AW-1:0] mac_a_q, mac_a_d;
    logic [AW-1:0] mac_b_q, mac_b_d;
    logic          mac_valid_in_q, mac_valid_in_d;
    logic [FW-1:0] res_q, res_d;
    logic          res_id_q, res_id_d;
    logic          res_sat_q, res_sat_d;
    logic          res_valid_q, res_valid_d;

    logic          arb_gnt;
    logic          arb_valid;
    logic          beat;
    logic [7:0]    done_inc;

    rr_arb2 u_arb (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_valid  (arb_valid)
    );

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_grant_d   = last_grant_q;
        issue_cnt_d    = issue_cnt_q;
        done_cnt_d     = done_cnt_q;
        mac_a_d        = mac_a_q;
        mac_b_d        = mac_b_q;
        res_d          = res_q;
        res_id_d       = res_id_q;
        res_sat_d      = res_sat_q;
        res_valid_d    = res_valid_q;

        beat           = (state_q == STREAM) && bus.in_valid[gnt_q];
        done_inc       = done_cnt_q + {7'd0, bus.mac_valid_out};
        mac_valid_in_d = beat;
        if (beat) begin
            mac_a_d = gnt_q ? bus.a1 : bus.a0;
            mac_b_d = gnt_q ? bus.b1 : bus.b0;
        end

        // Completion pulses only count once the accumulator has been cleared for this job.
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                issue_cnt_d = '0;
                done_cnt_d  = '0;
                state_d     = STREAM;
            end
            STREAM: begin
                done_cnt_d = done_inc;
                if (beat) begin
                    issue_cnt_d = issue_cnt_q + 8'd1;
                    if (issue_cnt_q == LAST_BEAT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                done_cnt_d = done_inc;
                if (done_inc == ALL_DONE) begin
                    res_d       = bus.mac_f;
                    res_id_d    = gnt_q;
                    res_sat_d   = is_sat(result_t'(bus.mac_f));
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d  = 1'b0;
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gnt_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            issue_cnt_q    <= '0;
            done_cnt_q     <= '0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            mac_valid_in_q <= 1'b0;
            res_q          <= '0;
            res_id_q       <= 1'b0;
            res_sat_q      <= 1'b0;
            res_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            last_grant_q   <= last_grant_d;
            issue_cnt_q    <= issue_cnt_d;
            done_cnt_q     <= done_cnt_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            mac_valid_in_q <= mac_valid_in_d;
            res_q          <= res_d;
            res_id_q       <= res_id_d;
            res_sat_q      <= res_sat_d;
            res_valid_q    <= res_valid_d;
        end
    end

    always_comb begin
        bus.in_ready     = (state_q == STREAM) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
        bus.mac_clr      = (state_q == CLEAR);
        bus.mac_a        = mac_a_q;
        bus.mac_b        = mac_b_q;
        bus.mac_valid_in = mac_valid_in_q;
        bus.res          = res_q;
        bus.res_id       = res_id_q;
        bus.res_sat      = res_sat_q;
        bus.res_valid    = res_valid_q;
    end

endmodule

// File: tb/tb_mac_dot_sched.sv
// Bench for mac_dot_sched: two instances (VEC_LEN 4 and 9) each driving a saturating MAC model.
module tb_mac_dot_sched;
    import mac_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_dot_sched_if if4 ();
    mac_dot_sched_if if9 ();

    mac_dot_sched #(.VEC_LEN(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    mac_dot_sched #(.VEC_LEN(9)) u_dut9 (.clk(clk), .reset(reset), .bus(if9.slave));

    logic                    sel;
    logic [1:0]              req;
    logic [1:0]              inValid;
    logic signed [11:0]      a0, b0, a1, b1;
    logic                    resReady;

    assign if4.req       = sel ? 2'b00 : req;
    assign if9.req       = sel ? req : 2'b00;
    assign if4.in_valid  = sel ? 2'b00 : inValid;
    assign if9.in_valid  = sel ? inValid : 2'b00;
    assign if4.res_ready = sel ? 1'b0 : resReady;
    assign if9.res_ready = sel ? resReady : 1'b0;
    assign if4.a0 = a0;  assign if4.b0 = b0;  assign if4.a1 = a1;  assign if4.b1 = b1;
    assign if9.a0 = a0;  assign if9.b0 = b0;  assign if9.a1 = a1;  assign if9.b1 = b1;

    logic [1:0]         inReady;
    logic signed [23:0] resOut;
    logic               resId, resSat, resValid, obsClr, obsMvi;
    logic [11:0]        obsA, obsB;
    assign inReady  = sel ? if9.in_ready     : if4.in_ready;
    assign resOut   = sel ? if9.res          : if4.res;
    assign resId    = sel ? if9.res_id       : if4.res_id;
    assign resSat   = sel ? if9.res_sat      : if4.res_sat;
    assign resValid = sel ? if9.res_valid    : if4.res_valid;
    assign obsClr   = sel ? if9.mac_clr      : if4.mac_clr;
    assign obsMvi   = sel ? if9.mac_valid_in : if4.mac_valid_in;
    assign obsA     = sel ? if9.mac_a        : if4.mac_a;
    assign obsB     = sel ? if9.mac_b        : if4.mac_b;

    // Reference MAC: signed 12x12 product into a 24-bit accumulator that clamps at the rails.
    function automatic logic [23:0] macStep(input logic [23:0] f, input logic [11:0] a,
                                             input logic [11:0] b);
        longint s;
        s = longint'($signed(f)) + longint'($signed(a)) * longint'($signed(b));
        if (s > 64'sd8388607)  s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return s[23:0];
    endfunction

    logic [23:0] f4 = '0, f9 = '0;
    logic        vo4 = 1'b0, vo9 = 1'b0;
    always @(posedge clk) begin
        if (reset || if4.mac_clr) begin
            f4 <= '0; vo4 <= 1'b0;
        end else begin
            vo4 <= if4.mac_valid_in;
            if (if4.mac_valid_in) f4 <= macStep(f4, if4.mac_a, if4.mac_b);
        end
        if (reset || if9.mac_clr) begin
            f9 <= '0; vo9 <= 1'b0;
        end else begin
            vo9 <= if9.mac_valid_in;
            if (if9.mac_valid_in) f9 <= macStep(f9, if9.mac_a, if9.mac_b);
        end
    end
    assign if4.mac_f = f4;  assign if4.mac_valid_out = vo4;
    assign if9.mac_f = f9;  assign if9.mac_valid_out = vo9;

    int clrCnt = 0;
    int mviCnt = 0;
    always @(posedge clk) begin
        if (obsClr) clrCnt <= clrCnt + 1;
        if (obsMvi) mviCnt <= mviCnt + 1;
    end

    typedef struct packed {
        logic               sel;
        logic               doReset;
        logic [1:0]         req;
        logic               id;
        logic [7:0]         n;
        logic [3:0][11:0]   a;
        logic [3:0][11:0]   b;
        logic [15:0]        pat;
        logic [3:0]         hold;
        logic signed [23:0] expRes;
        logic               expSat;
    } row_t;

    typedef struct packed {
        logic signed [23:0] res;
        logic               id;
        logic               sat;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    row_t rows[7];

    function automatic row_t mkRow(input logic s, input logic rst, input logic [1:0] rq,
                                   input logic i, input int n,
                                   input int x0, input int x1, input int x2, input int x3,
                                   input int y0, input int y1, input int y2, input int y3,
                                   input logic [15:0] pat, input int hold,
                                   input int er, input logic es);
        row_t r;
        r.sel = s; r.doReset = rst; r.req = rq; r.id = i; r.n = 8'(n);
        r.a[0] = 12'(x0); r.a[1] = 12'(x1); r.a[2] = 12'(x2); r.a[3] = 12'(x3);
        r.b[0] = 12'(y0); r.b[1] = 12'(y1); r.b[2] = 12'(y2); r.b[3] = 12'(y3);
        r.pat = pat; r.hold = 4'(hold); r.expRes = 24'(er); r.expSat = es;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic driveBeat(input logic id, input logic [11:0] av, input logic [11:0] bv,
                             input logic v);
        a0 = id ? 12'sd0 : av;  b0 = id ? 12'sd0 : bv;
        a1 = id ? av : 12'sd0;  b1 = id ? bv : 12'sd0;
        inValid = v ? (id ? 2'b10 : 2'b01) : 2'b00;
    endtask

    task automatic applyStimulus(input row_t r);
        int   c0, m0, k, pos;
        bit   ok, acc;
        exp_t e;
        if (r.doReset) begin
            req = 2'b00; inValid = 2'b00; reset = 1'b1;
            repeat (2) tick;
            reset = 1'b0;
        end
        sel = r.sel; req = r.req; resReady = 1'b0;
        driveBeat(r.id, 12'd0, 12'd0, 1'b0);
        c0 = clrCnt; m0 = mviCnt;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (inReady[r.id]) begin ok = 1'b1; break; end
            tick;
        end
        checkOutput("grant_seen", longint'(ok), 1);
        if (!ok) return;
        checkOutput("in_ready_other_port", longint'(inReady[~r.id]), 0);
        k = 0; pos = 0;
        while (k < int'(r.n) && pos < 200) begin
            driveBeat(r.id, (k < 4) ? r.a[k] : r.a[3], (k < 4) ? r.b[k] : r.b[3], r.pat[pos % 16]);
            acc = inValid[r.id] && inReady[r.id];
            if (acc && k == int'(r.n) - 1) begin
                e.res = r.expRes; e.id = r.id; e.sat = r.expSat;
                sbq.push_back(e);
            end
            tick;
            if (acc) k++;
            pos++;
        end
        driveBeat(r.id, 12'd0, 12'd0, 1'b0);
        checkOutput("beats_accepted", k, int'(r.n));
        checkOutput("in_ready_after_stream", longint'(inReady), 0);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (resValid) begin ok = 1'b1; break; end
            tick;
        end
        checkOutput("res_valid_seen", longint'(ok), 1);
        if (!ok) return;
        checkOutput("scoreboard_nonempty", longint'(sbq.size() > 0), 1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        checkOutput("res", longint'(resOut), longint'(e.res));
        checkOutput("res_id", longint'(resId), longint'(e.id));
        checkOutput("res_sat", longint'(resSat), longint'(e.sat));
        checkOutput("mac_clr_pulses", clrCnt - c0, 1);
        checkOutput("mac_valid_in_pulses", mviCnt - m0, int'(r.n));
        for (int h = 0; h < int'(r.hold); h++) begin
            tick;
            checkOutput("hold_res_valid", longint'(resValid), 1);
            checkOutput("hold_res", longint'(resOut), longint'(e.res));
            checkOutput("hold_res_id", longint'(resId), longint'(e.id));
            checkOutput("hold_res_sat", longint'(resSat), longint'(e.sat));
            checkOutput("hold_in_ready", longint'(inReady), 0);
            checkOutput("hold_no_clear", longint'(obsClr), 0);
        end
        resReady = 1'b1; req = 2'b00;
        tick;
        resReady = 1'b0;
        checkOutput("res_valid_drop", longint'(resValid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got hang, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        sel = 1'b0; req = 2'b00; inValid = 2'b00; resReady = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        reset = 1'b1;

        rows[0] = mkRow(0, 0, 2'b01, 0, 4, 1, 2, 3, 4, 5, 6, 7, 8, 16'hFFFF, 0, 70, 0);
        rows[1] = mkRow(0, 1, 2'b11, 0, 4, 2, 2, 2, 2, 2, 2, 2, 2, 16'hFFFF, 0, 16, 0);
        rows[2] = mkRow(0, 0, 2'b11, 1, 4, -3, -3, -3, -3, 4, 4, 4, 4, 16'hFFFF, 0, -48, 0);
        rows[3] = mkRow(0, 0, 2'b11, 0, 4, 1, 2, 3, 4, 1, 1, 1, 1, 16'h0059, 0, 10, 0);
        rows[4] = mkRow(1, 0, 2'b01, 0, 9, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023,
                        16'hFFFF, 0, 8388607, 1);
        rows[5] = mkRow(1, 0, 2'b10, 1, 9, -1024, -1024, -1024, -1024, 1023, 1023, 1023, 1023,
                        16'hFFFF, 0, -8388608, 1);
        rows[6] = mkRow(0, 0, 2'b11, 1, 4, 7, -2, 5, 0, 3, 9, -4, 100, 16'hFFFF, 3, -17, 0);

        repeat (3) tick;
        checkOutput("rst_in_ready", longint'(inReady), 0);
        checkOutput("rst_mac_valid_in", longint'(obsMvi), 0);
        checkOutput("rst_mac_clr", longint'(obsClr), 0);
        checkOutput("rst_mac_a", longint'(obsA), 0);
        checkOutput("rst_mac_b", longint'(obsB), 0);
        checkOutput("rst_res", longint'(resOut), 0);
        checkOutput("rst_res_id", longint'(resId), 0);
        checkOutput("rst_res_sat", longint'(resSat), 0);
        checkOutput("rst_res_valid", longint'(resValid), 0);
        reset = 1'b0;
        tick;
        checkOutput("idle_no_clear", longint'(obsClr), 0);

        for (int i = 0; i < 7; i++) applyStimulus(rows[i]);

        // Partial job of two beats killed by reset, then a clean job must not see stale sums.
        sel = 1'b0; req = 2'b01;
        for (int c = 0; c < 30 && !inReady[0]; c++) tick;
        checkOutput("partial_grant", longint'(inReady[0]), 1);
        for (int k = 0; k < 2; k++) begin
            driveBeat(1'b0, 12'd5, 12'd5, 1'b1);
            tick;
        end
        driveBeat(1'b0, 12'd0, 12'd0, 1'b0);
        reset = 1'b1;
        tick;
        checkOutput("midreset_res_valid", longint'(resValid), 0);
        checkOutput("midreset_in_ready", longint'(inReady), 0);
        tick;
        reset = 1'b0;
        applyStimulus(mkRow(0, 0, 2'b01, 0, 4, 1, 1, 1, 1, 1, 1, 1, 1, 16'hFFFF, 0, 4, 0));
        checkOutput("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_dot_sched.md
Name: mac_dot_sched

Overview:
Round-robin scheduler that shares one part3_mac (signed 12x12, 24-bit saturating accumulator) between two requesters, each computing a VEC_LEN-element dot product. Per granted job it clears the MAC accumulator, streams the requester's operand pairs into the MAC, and counts MAC valid_out pulses. When the last product is accumulated it captures f as the result and holds it until the consumer accepts it. It sits between the requester front-ends and the MAC instance at top level.

Parameters:
VEC_LEN, 4, operand pairs per job (2..255)
AW, 12, operand width (matches MAC a/b)
FW, 24, accumulator/result width (matches MAC f)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; top ties MAC reset = reset | mac_clr
req  in  2  req[i]=requester i has a job pending
a0, b0  in  AW each  signed operands from requester 0
a1, b1  in  AW each  signed operands from requester 1
in_valid  in  2  operand beat valid, per requester
in_ready  out  2  operand beat accepted, per requester
mac_a, mac_b  out  AW each  registered operands to MAC
mac_valid_in  out  1  registered valid to MAC
mac_clr  out  1  one-cycle accumulator clear pulse
mac_f  in  FW  MAC accumulator output
mac_valid_out  in  1  MAC valid_out
res  out  FW  captured dot-product result (signed)
res_id  out  1  requester that owns res
res_sat  out  1  res equals +max or -min (saturated)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result

Behaviour:
- Reset: state=IDLE; in_ready=0, mac_valid_in=0, mac_clr=0, mac_a=mac_b=0, res=0, res_id=0, res_sat=0, res_valid=0; last_grant=1, so requester 0 wins the first tie. Counters are 0.
- IDLE: if req!=0, grant the requester other than last_grant when it requests, otherwise the sole requester. Latch gnt. Go to CLEAR.
- CLEAR (1 cycle): mac_clr=1. Zero issue_cnt and done_cnt. Go to STREAM.
- STREAM: in_ready[gnt]=1 and in_ready[~gnt]=0 (combinational from state/gnt).
  - On in_valid[gnt]: next cycle mac_a/mac_b=a/b of gnt and mac_valid_in=1; issue_cnt++.
  - Otherwise mac_valid_in=0 next cycle.
  - Bubbles are allowed and do not stall correctness.
  - On the beat that makes issue_cnt==VEC_LEN, go to DRAIN. in_ready is 0 from the following cycle.
- Any state after CLEAR: each mac_valid_out pulse increments done_cnt.
- DRAIN: when done_cnt reaches VEC_LEN (counting a pulse arriving this cycle):
  - capture res<=mac_f, res_id<=gnt, and res_sat<=(mac_f==2^(FW-1)-1 || mac_f==-2^(FW-1));
  - res_valid<=1; go to DONE.
- DONE: hold res* stable. On res_valid&res_ready: res_valid<=0, last_grant<=gnt, go to IDLE. A new job's CLEAR starts no earlier than the cycle after acceptance.
- Requester deasserting req mid-job is ignored; the grant holds until all VEC_LEN beats are accepted.
- A requester not granted sees in_ready=0 and must hold its data.
- Reset mid-job: return to IDLE next edge and discard the partial job. MAC is also cleared through the reset OR.
- MAC valid_out while IDLE/DONE is ignored and is not counted.
- Arithmetic: the scheduler does no math. Saturation is performed by the MAC; res_sat is a pure compare on the captured value.

Decomposition:
- Package mac_sched_pkg:
  - state enum {IDLE, CLEAR, STREAM, DRAIN, DONE};
  - localparams FMAX=2^(FW-1)-1 and FMIN=-2^(FW-1);
  - operand and result typedefs (signed [AW-1:0], signed [FW-1:0]).
- One sub-module: rr_arb2. It is a 2-way round-robin arbiter with inputs req and last_grant, producing gnt and gnt_valid.

Test Plan:
- VEC_LEN=4, req=01. Requester 0 streams a={1,2,3,4}, b={5,6,7,8} -> mac_clr pulses once, then res=70, res_id=0, res_sat=0, res_valid high until res_ready.
- req=11 from reset, with job0 a=b={2,2,2,2} and job1 a={-3,-3,-3,-3}, b={4,4,4,4} -> res=16 id=0 first, then res=-48 id=1. The next simultaneous request grants requester 0 again.
- VEC_LEN=9, a=b=1023 on every beat -> res=8388607, res_sat=1. Then a=-1024, b=1023 ×9 -> res=-8388608, res_sat=1, with no carry-over thanks to mac_clr.
- in_valid toggled 1,0,0,1,1,0,1 for a={1,2,3,4}, b=1 -> exactly 4 mac_valid_in pulses, res=10.
- reset asserted after 2 beats of a job, then a fresh job a=b={1,1,1,1} -> res=4 with no stale accumulation, res_valid=0 during reset.
- res_ready held 0 for 3 cycles in DONE -> res, res_id and res_sat are stable, in_ready=0, and a pending req on the other port waits.
